// File: rtl/spi_fifo_sync_pkg.sv
// rtl/spi_fifo_sync_pkg.sv - shared constants and helpers for the SPI data-path FIFOs
package spi_fifo_sync_pkg;

    localparam int SPI_FIFO_DATA_W = 8;
    localparam int SPI_FIFO_DEPTH  = 261;

    // Bits needed to hold values 0..v-1; used for pointer and count widths.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/spi_fifo_sync_if.sv
// rtl/spi_fifo_sync_if.sv - FIFO data/control/status bundle between producer, consumer and FIFO
interface spi_fifo_sync_if
    import spi_fifo_sync_pkg::*;
#(
    parameter int DATA_W = SPI_FIFO_DATA_W,
    parameter int DEPTH  = SPI_FIFO_DEPTH
);
    localparam int CNT_W = clog2(DEPTH + 1);

    logic              flush;
    logic              wr_en;
    logic [DATA_W-1:0] data_in;
    logic              rd_en;
    logic [DATA_W-1:0] data_out;
    logic              empty;
    logic              full;
    logic              almost_empty;
    logic              almost_full;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              underflow;
    logic              err_clr;

    modport master (
        output flush, wr_en, data_in, rd_en, err_clr,
        input  data_out, empty, full, almost_empty, almost_full, count, overflow, underflow
    );

    modport slave (
        input  flush, wr_en, data_in, rd_en, err_clr,
        output data_out, empty, full, almost_empty, almost_full, count, overflow, underflow
    );

endinterface

// File: rtl/spi_fifo_ram.sv
// rtl/spi_fifo_ram.sv - simple dual-port RAM, synchronous write, asynchronous read
module spi_fifo_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 261,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/spi_fifo_sync.sv
// rtl/spi_fifo_sync.sv - parametrised synchronous FIFO with flush, level flags and sticky errors
module spi_fifo_sync
    import spi_fifo_sync_pkg::*;
#(
    parameter int DATA_W   = SPI_FIFO_DATA_W,
    parameter int DEPTH    = SPI_FIFO_DEPTH,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1,
    parameter int FWFT     = 1
) (
    input  logic            clk,
    input  logic            reset,
    spi_fifo_sync_if.slave  bus
);

    localparam int CNT_W = clog2(DEPTH + 1);
    localparam int PTR_W = clog2(DEPTH);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AE_LEVEL);

    logic [PTR_W-1:0]  rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt;
    logic [CNT_W-1:0]  count_q, count_nxt;
    logic              empty_q, full_q, ae_q, af_q;
    logic              ovf_q, udf_q;
    logic [DATA_W-1:0] dout_q, ram_rdata;
    logic              reading, writing, ram_we;

    // A full FIFO still takes a write when the same cycle frees a slot.
    assign reading = bus.rd_en && !empty_q;
    assign writing = bus.wr_en && (!full_q || reading);
    assign ram_we  = writing && !bus.flush && !reset;

    always_comb begin
        rd_ptr_nxt = rd_ptr;
        wr_ptr_nxt = wr_ptr;
        count_nxt  = count_q;
        if (reading) begin
            rd_ptr_nxt = (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
        end
        if (writing) begin
            wr_ptr_nxt = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
        end
        if (writing && !reading) begin
            count_nxt = count_q + 1'b1;
        end else if (reading && !writing) begin
            count_nxt = count_q - 1'b1;
        end
    end

    spi_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr),
        .wdata (bus.data_in),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            ae_q    <= 1'b1;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            dout_q  <= '0;
        end else if (bus.flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            ae_q    <= 1'b1;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
        end else begin
            rd_ptr  <= rd_ptr_nxt;
            wr_ptr  <= wr_ptr_nxt;
            count_q <= count_nxt;
            empty_q <= (count_nxt == '0);
            full_q  <= (count_nxt == CNT_FULL);
            af_q    <= (count_nxt >= CNT_AF);
            ae_q    <= (count_nxt <= CNT_AE);
            if (reading) begin
                dout_q <= ram_rdata;
            end
        end
    end

    // A new error in the err_clr cycle leaves the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= (ovf_q && !bus.err_clr) || (!bus.flush && bus.wr_en && !writing);
            udf_q <= (udf_q && !bus.err_clr) || (!bus.flush && bus.rd_en && !reading);
        end
    end

    assign bus.data_out     = (FWFT != 0) ? (empty_q ? '0 : ram_rdata) : dout_q;
    assign bus.empty        = empty_q;
    assign bus.full         = full_q;
    assign bus.almost_empty = ae_q;
    assign bus.almost_full  = af_q;
    assign bus.count        = count_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;

endmodule
